// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory-link initiator.
//   state_t      : frame sequencer states
//   ADDR_W       : address field width
//   DATA_W       : data field width
//   FRAME_W      : full serial frame width
//   RW_READ/WRITE: R/W bit encoding shared with the slave decoder
//   build_frame  : assembles {addr, rw, data}; data is zeroed on reads
package spi_pkg;

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FRAME_W = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    // Reads carry an all-zero data field so the slave sees a clean frame.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [ADDR_W-1:0] addr,
        input logic              rw,
        input logic [DATA_W-1:0] wdata
    );
        return {addr, rw, (rw == RW_READ) ? DATA_W'(0) : wdata};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing engine: a half-period counter paced by CLKDIV and a bit counter
// over the 16 frame bits. The half-period counter also times the LEAD, TRAIL
// and GAP phases for the sequencer.
//   clk, reset  : system clock, synchronous active-high reset
//   run         : counter enable; low holds everything cleared
//   go          : sequencer is in LEAD; the next half-period end starts bit 0
//   sclk        : serial clock, registered, idles low
//   half_end_c  : current cycle is the last of a half-period
//   rise_stb    : sclk rises at the end of this cycle
//   fall_stb    : sclk falls at the end of this cycle
//   last_bit    : the current bit period is bit 15
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLKDIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic go,
    output logic sclk,
    output logic half_end_c,
    output logic rise_stb,
    output logic fall_stb,
    output logic last_bit
);

    localparam int unsigned HC_W  = $clog2(CLKDIV);
    localparam int unsigned BIT_W = $clog2(FRAME_W);

    logic [HC_W-1:0]  half_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             active;

    // Strobes are decoded one cycle ahead of the sclk register so the
    // sequencer can move mosi on the very edge that drops sclk.
    assign half_end_c = run && (half_cnt == HC_W'(CLKDIV - 1));
    assign last_bit   = (bit_cnt == BIT_W'(FRAME_W - 1));
    assign rise_stb   = half_end_c && !sclk && (go || (active && !last_bit));
    assign fall_stb   = half_end_c && sclk;

    // Half-period counter, sclk register and bit counter.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
            sclk     <= 1'b0;
        end else begin
            half_cnt <= half_end_c ? '0 : half_cnt + 1'b1;
            if (rise_stb) begin
                sclk   <= 1'b1;
                active <= 1'b1;
                // bit 0 starts from LEAD; later rises advance the bit index
                bit_cnt <= go ? '0 : bit_cnt + 1'b1;
            end else if (fall_stb) begin
                sclk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI initiator for the lab SPI memory slave. Sends one 16-bit frame
// {addr, rw, data} MSB first in mode 0 and captures the read byte from miso.
// Every edge is spaced CLKDIV clk cycles apart to suit the slave's input
// synchronizers.
//   clk, reset : system clock, synchronous active-high reset
//   start      : request strobe, taken only while busy is low
//   rw         : 1 = read, 0 = write
//   addr       : 7-bit memory address
//   wdata      : write byte, ignored on reads
//   busy       : from the cycle after acceptance through the end of GAP
//   done       : one-cycle pulse as cs returns high
//   rdata      : last read byte, updated only by read frames
//   sclk       : serial clock, idles low
//   cs         : chip select, active low
//   mosi       : serial data out
//   miso       : serial data in
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLKDIV = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    state_t               state;
    logic [FRAME_W-2:0]   frame_q;   // bits still to be sent after mosi
    logic                 rw_q;
    logic [DATA_W-1:0]    cap_q;
    logic [FRAME_W-1:0]   frame_c;

    logic run_c;
    logic go_c;
    logic half_end_c;
    logic rise_stb;
    logic fall_stb;
    logic last_bit;

    assign frame_c = build_frame(addr, rw, wdata);
    assign run_c   = (state != IDLE);
    assign go_c    = (state == LEAD);

    spi_sclk_gen #(
        .CLKDIV (CLKDIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .run        (run_c),
        .go         (go_c),
        .sclk       (sclk),
        .half_end_c (half_end_c),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .last_bit   (last_bit)
    );

    // Frame sequencer with registered pin and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            frame_q <= '0;
            rw_q    <= RW_WRITE;
            cap_q   <= '0;
            rdata   <= '0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mosi    <= frame_c[FRAME_W-1];
                        frame_q <= frame_c[FRAME_W-2:0];
                        rw_q    <= rw;
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LEAD;
                    end
                end
                LEAD: begin
                    if (half_end_c) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Rises inside SHIFT are bits 1..15; an 8-bit shifter
                    // therefore ends up holding exactly bits 8..15.
                    if (rise_stb && (rw_q == RW_READ)) begin
                        cap_q <= {cap_q[DATA_W-2:0], miso};
                    end
                    if (fall_stb && !last_bit) begin
                        mosi    <= frame_q[FRAME_W-2];
                        frame_q <= {frame_q[FRAME_W-3:0], 1'b0};
                    end
                    // End of the low half of bit 15.
                    if (half_end_c && !sclk && last_bit) begin
                        state <= TRAIL;
                        if (rw_q == RW_READ) begin
                            rdata <= cap_q;
                        end
                    end
                end
                TRAIL: begin
                    if (half_end_c) begin
                        cs    <= 1'b1;
                        mosi  <= 1'b0;
                        done  <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (half_end_c) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master at CLKDIV=4 with a mode-0 slave model on the pins.
module tb_spi_master;
    import spi_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    always #5 clk = ~clk;

    spi_master #(.CLKDIV(D)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .rdata (rdata),
        .sclk  (sclk),
        .cs    (cs),
        .mosi  (mosi),
        .miso  (miso)
    );

    // Slave model: samples mosi on rising sclk, drives miso on falling sclk.
    logic [15:0] sl_rx;
    logic [7:0]  sl_tx;
    logic [7:0]  sl_rbyte;
    logic [15:0] sl_last;
    int          sl_cnt    = 0;
    int          sl_frames = 0;

    always @(negedge cs or posedge sclk) begin
        if (!cs && sclk) begin
            sl_rx  = {sl_rx[14:0], mosi};
            sl_cnt = sl_cnt + 1;
        end else if (!cs) begin
            sl_cnt = 0;
            sl_rx  = '0;
        end
    end

    always @(negedge sclk or negedge cs) begin
        if (!cs && sl_cnt == 8) begin
            sl_tx = sl_rx[0] ? sl_rbyte : 8'h00;
            miso  = sl_tx[7];
        end else if (!cs && sl_cnt > 8 && sl_cnt < 16) begin
            sl_tx = {sl_tx[6:0], 1'b0};
            miso  = sl_tx[7];
        end else begin
            miso = 1'b0;
        end
    end

    always @(posedge cs) begin
        if (sl_cnt == 16) begin
            sl_last   = sl_rx;
            sl_frames = sl_frames + 1;
        end
    end

    // Scoreboard and bookkeeping.
    logic [15:0] exp_frame_q[$];
    logic [7:0]  exp_rdata_q[$];
    logic [7:0]  model_rdata;
    logic [15:0] ef;
    logic [7:0]  er;
    int n_vec = 0;
    int n_bad = 0;

    int cs_first, cs_low_cnt, done_cnt, done_cyc, busy_low, rise_cnt, first_rise, mosi_viol;
    int frames_before;
    logic busy_c1;
    logic [7:0] rdata_done;
    logic pr_cs, pr_sclk, pr_busy, pr_done;

    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] w, input bit push);
        rw = r; addr = a; wdata = w; start = 1'b1;
        if (push) begin
            exp_frame_q.push_back({a, r, (r == RW_READ) ? 8'h00 : w});
            if (r == RW_READ) model_rdata = sl_rbyte;
            exp_rdata_q.push_back(model_rdata);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Observes cycles 1..n of a frame (called during cycle 1); optionally
    // pulses a stray start or a reset during a given cycle.
    task automatic watch(input int n, input int stray_cyc, input int rst_cyc);
        int last_chg, last_rise;
        logic prev_sclk, prev_mosi;
        cs_first = 0; cs_low_cnt = 0; done_cnt = 0; done_cyc = 0; busy_low = 0;
        rise_cnt = 0; first_rise = 0; mosi_viol = 0;
        last_chg = 1; last_rise = -1000; prev_sclk = 1'b0; prev_mosi = mosi;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (!cs) begin cs_low_cnt++; if (cs_first == 0) cs_first = c; end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin done_cyc = c; rdata_done = rdata; end
            end
            if (c == 1) busy_c1 = busy;
            if (!busy && busy_low == 0 && c > 1) busy_low = c;
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                if (first_rise == 0) first_rise = c;
                if (c - last_chg < D) mosi_viol++;
                last_rise = c;
            end
            if (c > 1 && mosi !== prev_mosi) begin
                if (c - last_rise < D) mosi_viol++;
                last_chg = c;
            end
            prev_sclk = sclk; prev_mosi = mosi;
            if (rst_cyc != 0 && c == rst_cyc + 1) begin
                pr_cs = cs; pr_sclk = sclk; pr_busy = busy; pr_done = done;
            end
            start = (c == stray_cyc);
            if (c == stray_cyc) begin rw = 1'b0; addr = 7'h7F; wdata = 8'h00; end
            reset = (c == rst_cyc);
        end
        start = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        int rises;
        logic ps;
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_rdata = 8'h00;
        n_vec++; if (cs !== 1'b1)     begin n_bad++; $display("FAIL rst_cs got %b exp 1", cs); end
        n_vec++; if (sclk !== 1'b0)   begin n_bad++; $display("FAIL rst_sclk got %b exp 0", sclk); end
        n_vec++; if (mosi !== 1'b0)   begin n_bad++; $display("FAIL rst_mosi got %b exp 0", mosi); end
        n_vec++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0)   begin n_bad++; $display("FAIL rst_done got %b exp 0", done); end
        n_vec++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata got %h exp 00", rdata); end
        rises = 0; ps = sclk;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        n_vec++; if (rises !== 0) begin n_bad++; $display("FAIL rst_idle_sclk got %0d rises exp 0", rises); end
    endtask

    task automatic test_write();
        sl_rbyte = 8'hEE;
        issue(RW_WRITE, 7'h2A, 8'hC3, 1);
        watch(141, 0, 0);
        n_vec++; if (cs_first !== 1)      begin n_bad++; $display("FAIL wr_cs_fall got %0d exp 1", cs_first); end
        n_vec++; if (cs_low_cnt !== 34*D) begin n_bad++; $display("FAIL wr_cs_low got %0d exp %0d", cs_low_cnt, 34*D); end
        n_vec++; if (done_cyc !== 34*D+1) begin n_bad++; $display("FAIL wr_done_cyc got %0d exp %0d", done_cyc, 34*D+1); end
        n_vec++; if (done_cnt !== 1)      begin n_bad++; $display("FAIL wr_done_cnt got %0d exp 1", done_cnt); end
        n_vec++; if (busy_c1 !== 1'b1)    begin n_bad++; $display("FAIL wr_busy_c1 got %b exp 1", busy_c1); end
        n_vec++; if (busy_low !== 35*D+1) begin n_bad++; $display("FAIL wr_busy_low got %0d exp %0d", busy_low, 35*D+1); end
        n_vec++; if (first_rise !== 1+D)  begin n_bad++; $display("FAIL wr_first_rise got %0d exp %0d", first_rise, 1+D); end
        n_vec++; if (rise_cnt !== 16)     begin n_bad++; $display("FAIL wr_rises got %0d exp 16", rise_cnt); end
        n_vec++; if (mosi_viol !== 0)     begin n_bad++; $display("FAIL wr_mosi_setup got %0d violations exp 0", mosi_viol); end
        if (done_cnt > 0 && exp_frame_q.size() > 0) begin
            ef = exp_frame_q.pop_front(); er = exp_rdata_q.pop_front();
            n_vec++; if (sl_last !== ef)    begin n_bad++; $display("FAIL wr_frame got %h exp %h", sl_last, ef); end
            n_vec++; if (rdata_done !== er) begin n_bad++; $display("FAIL wr_rdata got %h exp %h", rdata_done, er); end
        end else begin
            n_vec++; n_bad++; $display("FAIL wr_scoreboard got %0d done exp 1", done_cnt);
        end
    endtask

    task automatic test_read();
        sl_rbyte = 8'hA5;
        issue(RW_READ, 7'h2A, 8'h77, 1);
        watch(141, 0, 0);
        n_vec++; if (rise_cnt !== 16) begin n_bad++; $display("FAIL rd_rises got %0d exp 16", rise_cnt); end
        n_vec++; if (done_cnt !== 1)  begin n_bad++; $display("FAIL rd_done_cnt got %0d exp 1", done_cnt); end
        if (done_cnt > 0 && exp_frame_q.size() > 0) begin
            ef = exp_frame_q.pop_front(); er = exp_rdata_q.pop_front();
            n_vec++; if (sl_last !== ef)    begin n_bad++; $display("FAIL rd_frame got %h exp %h", sl_last, ef); end
            n_vec++; if (rdata_done !== er) begin n_bad++; $display("FAIL rd_rdata got %h exp %h", rdata_done, er); end
        end else begin
            n_vec++; n_bad++; $display("FAIL rd_scoreboard got %0d done exp 1", done_cnt);
        end
        n_vec++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_rdata_hold got %h exp a5", rdata); end
    endtask

    task automatic test_back_to_back();
        frames_before = sl_frames;
        issue(RW_WRITE, 7'h15, 8'h3E, 1);
        watch(141, 40, 0);
        n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_start_done got %0d exp 1", done_cnt); end
        n_vec++; if (sl_frames - frames_before !== 1) begin n_bad++; $display("FAIL busy_start_frames got %0d exp 1", sl_frames - frames_before); end
        if (done_cnt > 0 && exp_frame_q.size() > 0) begin
            ef = exp_frame_q.pop_front(); er = exp_rdata_q.pop_front();
            n_vec++; if (sl_last !== ef)    begin n_bad++; $display("FAIL busy_start_frame got %h exp %h", sl_last, ef); end
            n_vec++; if (rdata_done !== er) begin n_bad++; $display("FAIL busy_start_rdata got %h exp %h", rdata_done, er); end
        end else begin
            n_vec++; n_bad++; $display("FAIL busy_start_scoreboard got %0d done exp 1", done_cnt);
        end
        // still inside cycle 141: first cycle with busy low
        issue(RW_WRITE, 7'h01, 8'h81, 1);
        watch(141, 0, 0);
        n_vec++; if (cs_first !== 1)      begin n_bad++; $display("FAIL b2b_cs_fall got %0d exp 1", cs_first); end
        n_vec++; if (done_cyc !== 34*D+1) begin n_bad++; $display("FAIL b2b_done_cyc got %0d exp %0d", done_cyc, 34*D+1); end
        if (done_cnt > 0 && exp_frame_q.size() > 0) begin
            ef = exp_frame_q.pop_front(); er = exp_rdata_q.pop_front();
            n_vec++; if (sl_last !== ef)    begin n_bad++; $display("FAIL b2b_frame got %h exp %h", sl_last, ef); end
            n_vec++; if (rdata_done !== er) begin n_bad++; $display("FAIL b2b_rdata got %h exp %h", rdata_done, er); end
        end else begin
            n_vec++; n_bad++; $display("FAIL b2b_scoreboard got %0d done exp 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        frames_before = sl_frames;
        issue(RW_WRITE, 7'h2A, 8'hC3, 0);
        watch(80, 0, 60);
        model_rdata = 8'h00;
        n_vec++; if (pr_cs !== 1'b1)   begin n_bad++; $display("FAIL mid_rst_cs got %b exp 1", pr_cs); end
        n_vec++; if (pr_sclk !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sclk got %b exp 0", pr_sclk); end
        n_vec++; if (pr_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b exp 0", pr_busy); end
        n_vec++; if (pr_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done_now got %b exp 0", pr_done); end
        n_vec++; if (done_cnt !== 0)   begin n_bad++; $display("FAIL mid_rst_done_cnt got %0d exp 0", done_cnt); end
        n_vec++; if (sl_frames !== frames_before) begin n_bad++; $display("FAIL mid_rst_frames got %0d exp %0d", sl_frames, frames_before); end
        n_vec++; if (rdata !== 8'h00)  begin n_bad++; $display("FAIL mid_rst_rdata got %h exp 00", rdata); end
        sl_rbyte = 8'h96;
        issue(RW_READ, 7'h33, 8'h00, 1);
        watch(141, 0, 0);
        n_vec++; if (done_cyc !== 34*D+1) begin n_bad++; $display("FAIL mid_rd_done_cyc got %0d exp %0d", done_cyc, 34*D+1); end
        if (done_cnt > 0 && exp_frame_q.size() > 0) begin
            ef = exp_frame_q.pop_front(); er = exp_rdata_q.pop_front();
            n_vec++; if (sl_last !== ef)    begin n_bad++; $display("FAIL mid_rd_frame got %h exp %h", sl_last, ef); end
            n_vec++; if (rdata_done !== er) begin n_bad++; $display("FAIL mid_rd_rdata got %h exp %h", rdata_done, er); end
        end else begin
            n_vec++; n_bad++; $display("FAIL mid_rd_scoreboard got %0d done exp 1", done_cnt);
        end
    endtask

    task automatic test_write_after_read();
        sl_rbyte = 8'h3C;
        issue(RW_READ, 7'h11, 8'h00, 1);
        watch(141, 0, 0);
        if (done_cnt > 0 && exp_frame_q.size() > 0) begin
            ef = exp_frame_q.pop_front(); er = exp_rdata_q.pop_front();
            n_vec++; if (sl_last !== ef)    begin n_bad++; $display("FAIL war_rd_frame got %h exp %h", sl_last, ef); end
            n_vec++; if (rdata_done !== er) begin n_bad++; $display("FAIL war_rd_rdata got %h exp %h", rdata_done, er); end
        end else begin
            n_vec++; n_bad++; $display("FAIL war_rd_scoreboard got %0d done exp 1", done_cnt);
        end
        sl_rbyte = 8'h81;
        issue(RW_WRITE, 7'h11, 8'hFF, 1);
        watch(141, 0, 0);
        if (done_cnt > 0 && exp_frame_q.size() > 0) begin
            ef = exp_frame_q.pop_front(); er = exp_rdata_q.pop_front();
            n_vec++; if (sl_last !== ef)    begin n_bad++; $display("FAIL war_wr_frame got %h exp %h", sl_last, ef); end
            n_vec++; if (rdata_done !== er) begin n_bad++; $display("FAIL war_wr_rdata got %h exp %h", rdata_done, er); end
        end else begin
            n_vec++; n_bad++; $display("FAIL war_wr_scoreboard got %0d done exp 1", done_cnt);
        end
        n_vec++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL war_rdata_hold got %h exp 3c", rdata); end
        n_vec++; if (exp_frame_q.size() !== 0) begin n_bad++; $display("FAIL sb_leftover got %0d exp 0", exp_frame_q.size()); end
    endtask

    initial begin
        sl_rbyte = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_write_after_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI initiator for the lab's SPI memory slave: serializes one 16-bit frame (7-bit address, R/W bit, 8-bit data) onto SCLK/CS/MOSI and captures read data from MISO. Sits between a host-side request interface (test harness or CPU-side register) and the pins driving the slave's input conditioners. It is the transmitting end of the same link the slave FSM decodes, so every rise/fall is spaced widely enough for the slave's synchronizers.

## Interface
- CLKDIV, 8: SCLK half-period in clk cycles; legal range ≥ 4, to cover slave input-conditioner latency.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; accepted only when busy=0.
- rw  input  1  1 = read, 0 = write (same encoding as the slave's R/W bit).
- addr  input  7  memory address.
- wdata  input  8  write data; ignored on reads.
- busy  output  1  high from the cycle after acceptance through the end of GAP.
- done  output  1  one-cycle pulse when CS returns high.
- rdata  output  8  last read byte; updated only by read frames.
- sclk  output  1  serial clock; idles low (mode 0).
- cs  output  1  chip select, active low.
- mosi  output  1  serial data to slave.
- miso  input  1  serial data from slave.

## Operation
- Frame = {addr[6:0], rw, data[7:0]}, MSB first, 16 bits. data = wdata on writes, 8'h00 on reads.
- States: IDLE → LEAD → SHIFT → TRAIL → GAP → IDLE.
- IDLE: cs=1, sclk=0, busy=0. If start=1, latch the frame and rw; next state LEAD.
- LEAD (CLKDIV cycles): cs=0, mosi=frame[15], sclk=0.
- SHIFT (16 bit periods, 2·CLKDIV cycles each): sclk high for the first CLKDIV cycles of each bit, low for the second.
  - On each rising SCLK, for bits 8..15 of a read frame, shift miso into an internal capture register.
  - On each falling SCLK, advance mosi to the next frame bit, except after bit 15.
- TRAIL (CLKDIV cycles): sclk=0, cs=0, mosi holds the last bit. On entry to TRAIL, copy the capture register to rdata on read frames.
- GAP (CLKDIV cycles): cs=1, mosi=0, busy=1. done=1 in the first GAP cycle only.
- start is ignored while busy=1; it is not queued.
- Reset, including mid-frame: the next edge forces IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0. No done pulse is emitted for the aborted frame.

## Timing
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00.
- Cycle numbering: start is sampled high at edge 0.
  - Cycle 1: cs falls, busy rises, mosi = bit 15.
  - Rising SCLK k (k = 0..15) at cycle 1 + CLKDIV + 2k·CLKDIV.
  - cs low for exactly 34·CLKDIV cycles.
  - done at cycle 1 + 34·CLKDIV.
  - busy low from cycle 1 + 35·CLKDIV.
- MOSI is stable for ≥ CLKDIV cycles on both sides of every rising SCLK.
- rdata is valid in the done cycle and holds until the next read completes.
- A new start is accepted in the first cycle busy=0. The minimum CS-high time between frames is therefore CLKDIV + 1 cycles.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE, LEAD, SHIFT, TRAIL, GAP);
  - localparams ADDR_W=7, DATA_W=8, FRAME_W=16;
  - RW_READ=1'b1, RW_WRITE=1'b0.
- Sub-module spi_sclk_gen:
  - half-period counter of width $clog2(CLKDIV) and a bit counter (0..15);
  - emits one-cycle rise_stb and fall_stb, plus a last_bit flag.
- The top level holds the FSM, frame shift register and capture register.

## Test plan
All scenarios run with CLKDIV=4 and a behavioural slave model (mode 0; drives MISO on falling SCLK).
- Reset check: hold reset 3 cycles, then release. Response: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=00; no SCLK edges for 50 cycles.
- Write frame: start with rw=0, addr=7'h2A, wdata=8'hC3. Response: the slave captures MOSI 16'h54C3; cs low cycles 1–136; done at cycle 137; busy low at 141; rdata unchanged.
- Read frame: start with rw=1, addr=7'h2A; the model returns 8'hA5. Response: MOSI header 8'h55 followed by eight zeros; rdata=8'hA5 at done; exactly 16 rising SCLK edges.
- Start while busy: pulse start again at cycle 40 with different addr/wdata. Response: frame unchanged; exactly one done. Then a back-to-back start at cycle 141 is accepted, with cs falling at 142.
- Reset mid-frame: assert reset at cycle 60 of a write. Response: at the next edge cs=1, sclk=0, busy=0; no done pulse. A following read completes normally.
- Write after read: a read returns 8'h3C, followed by a write of 8'hFF. Response: rdata stays 8'h3C after the write's done.
